// File: rtl/sig_capture_pkg.sv
// Shared types and helpers for the sig_capture window recorder.
package sig_capture_pkg;

    // Capture FSM state encodings.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int SC_WIDTH_DEFAULT      = 12;
    localparam int SC_DEPTH_LOG2_DEFAULT = 10;

    // True for the states in which the buffer is being written.
    function automatic logic is_busy_state(input state_e s);
        return (s == ST_PRE) || (s == ST_ARMED) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/sig_capture_if.sv
// Sample stream, capture control and read-back bundle for sig_capture.
interface sig_capture_if #(
    parameter int WIDTH      = 12,
    parameter int DEPTH_LOG2 = 10
) ();
    logic                  data_valid;
    logic [WIDTH-1:0]      data_in;
    logic                  arm;
    logic [DEPTH_LOG2-1:0] pre_cnt;
    logic                  trigger;
    logic                  busy;
    logic                  done;
    logic                  rd_en;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [WIDTH-1:0]      rd_data;
    logic                  rd_valid;

    // Host/stimulus side.
    modport master (
        output data_valid, data_in, arm, pre_cnt, trigger, rd_en, rd_addr,
        input  busy, done, rd_data, rd_valid
    );

    // Capture block side.
    modport slave (
        input  data_valid, data_in, arm, pre_cnt, trigger, rd_en, rd_addr,
        output busy, done, rd_data, rd_valid
    );
endinterface

// File: rtl/sig_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module sig_capture_ram #(
    parameter int WIDTH  = 12,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);
    logic [WIDTH-1:0] mem_q [2**ADDR_W];
    logic [WIDTH-1:0] rdata_q;

    // Write port; contents are deliberately never cleared.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; output holds its value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/sig_capture.sv
// Triggered window recorder with pre-trigger depth and logical-index read-back.
module sig_capture
    import sig_capture_pkg::*;
#(
    parameter int WIDTH      = SC_WIDTH_DEFAULT,
    parameter int DEPTH_LOG2 = SC_DEPTH_LOG2_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    sig_capture_if.slave cap
);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    state_e                state_q,  state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] fill_q,   fill_d;
    logic [DEPTH_LOG2-1:0] pre_q,    pre_d;
    logic [DEPTH_LOG2-1:0] start_q,  start_d;
    logic [DEPTH_LOG2:0]   remain_q, remain_d;
    logic                  busy_q, done_q, rd_valid_q;

    logic                  we_s;
    logic                  rd_fire_s;
    logic [DEPTH_LOG2-1:0] fill_inc_s;
    logic [DEPTH_LOG2:0]   remain_base_s;
    logic [DEPTH_LOG2-1:0] rd_phys_s;

    assign fill_inc_s    = fill_q + PTR_ONE;
    assign remain_base_s = DEPTH_CNT - {1'b0, pre_q};
    assign rd_fire_s     = (state_q == ST_DONE) && cap.rd_en && !cap.arm;
    assign rd_phys_s     = start_q + cap.rd_addr;

    // Next-state, pointer and counter logic; arm restarts from any state.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        pre_d    = pre_q;
        start_d  = start_q;
        remain_d = remain_q;
        we_s     = 1'b0;
        if (cap.arm) begin
            pre_d    = cap.pre_cnt;
            wr_ptr_d = '0;
            fill_d   = '0;
            state_d  = (cap.pre_cnt == '0) ? ST_ARMED : ST_PRE;
        end else begin
            case (state_q)
                ST_PRE: begin
                    if (cap.data_valid) begin
                        we_s     = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        fill_d   = fill_inc_s;
                        if (fill_inc_s == pre_q) begin
                            state_d = ST_ARMED;
                        end else begin
                            state_d = ST_PRE;
                        end
                    end else begin
                        state_d = ST_PRE;
                    end
                end
                ST_ARMED: begin
                    if (cap.data_valid) begin
                        we_s     = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end else begin
                        we_s     = 1'b0;
                    end
                    if (cap.trigger) begin
                        // The trigger-cycle sample lands at logical index pre_q.
                        start_d = wr_ptr_q - pre_q;
                        if (cap.data_valid) begin
                            remain_d = remain_base_s - CNT_ONE;
                            state_d  = (remain_base_s == CNT_ONE) ? ST_DONE : ST_POST;
                        end else begin
                            remain_d = remain_base_s;
                            state_d  = ST_POST;
                        end
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_POST: begin
                    if (cap.data_valid) begin
                        we_s     = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        remain_d = remain_q - CNT_ONE;
                        state_d  = (remain_q == CNT_ONE) ? ST_DONE : ST_POST;
                    end else begin
                        state_d = ST_POST;
                    end
                end
                ST_IDLE: state_d = ST_IDLE;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state, pointers, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            pre_q      <= '0;
            start_q    <= '0;
            remain_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            pre_q      <= pre_d;
            start_q    <= start_d;
            remain_q   <= remain_d;
            busy_q     <= is_busy_state(state_d);
            done_q     <= (state_d == ST_DONE);
            rd_valid_q <= rd_fire_s;
        end
    end

    sig_capture_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (cap.data_in),
        .re_i    (rd_fire_s),
        .raddr_i (rd_phys_s),
        .rdata_o (cap.rd_data)
    );

    assign cap.busy     = busy_q;
    assign cap.done     = done_q;
    assign cap.rd_valid = rd_valid_q;
endmodule
